uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver paired with the system's UART transmitter. Recovers 8-bit frames from the serial line using an oversampling clock, checks optional parity and the stop bit, and presents each accepted byte as a one-cycle valid pulse to the system controller. It sits between the RX pin (already synchronised to `clk`) and the RX-side data synchroniser/register-file path.

## Interface
- No parameters; data width is fixed at 8 bits and the frame format is fixed at 1 start bit, 8 data bits, optional parity and 1 stop bit.
- `clk`  in  1  oversampling clock, `Prescale` cycles per bit.
- `rst_n`  in  1  reset: one clock; reset is synchronous and active-low.
- `RX_IN`  in  1  serial line; idles high; already synchronous to `clk`.
- `Prescale`  in  6  oversampling ratio; legal values 8, 16, 32; other values give undefined behaviour.
- `Par_En`  in  1  1: a parity bit follows the data bits.
- `Par_Typ`  in  1  0: even parity, 1: odd parity.
- `P_DATA`  out  8  last accepted byte; bit 0 is the first data bit received.
- `Data_Valid`  out  1  one-cycle pulse when `P_DATA` is updated with a good frame.
- `Par_Err`  out  1  one-cycle pulse: the frame's parity bit mismatched.
- `Stp_Err`  out  1  one-cycle pulse: the frame's stop bit was sampled 0.

## Operation
- States:
  - IDLE: wait for `RX_IN`==0.
  - START: check the start bit.
  - DATA: receive 8 bits, LSB first.
  - PARITY: only when `Par_En`=1.
  - STOP: check the stop bit.
- Config latch: `Prescale`, `Par_En` and `Par_Typ` are captured on the IDLE→START transition and held for the whole frame. Changes mid-frame have no effect.
- Edge counter: runs 0..P-1 within each bit, where P is the latched prescale. It wraps to 0 at the bit boundary and the bit counter advances.
- Sampling:
  - `RX_IN` is sampled at edge counts P/2-1, P/2 and P/2+1.
  - The bit value is the 2-of-3 majority.
  - The majority result is registered and becomes usable the cycle after edge count P/2+1.
- START: if the majority value is 1, the edge was a glitch. Return to IDLE with no output activity.
- DATA: the majority bit is shifted into an internal shift register, LSB first.
- PARITY: the expected bit is the XOR of the 8 data bits, inverted when `Par_Typ`=1. The check result is held until frame end.
- STOP:
  - When the majority result is usable, exactly one of the following is asserted for one cycle:
    - `Data_Valid`, when there is no error; `P_DATA` loads the shift register in the same cycle.
    - Otherwise `Par_Err` and/or `Stp_Err`, as applicable.
  - The FSM returns to IDLE in that same cycle, so the remaining half stop bit is spent in IDLE and a start edge that follows immediately is caught.
- A frame with an error never updates `P_DATA`.
- Reset values: `P_DATA`=0x00, `Data_Valid`=0, `Par_Err`=0, `Stp_Err`=0, FSM in IDLE, all counters 0.
- Reset mid-frame: on the next clock edge every state bit and output takes its reset value and the partial frame is discarded.
- `RX_IN` held low in IDLE after a glitch return: detected again immediately. The start check then re-runs on each retry.

## Timing
- c0 is the first cycle in IDLE with `RX_IN`=0.
- START is entered at c0+1 with edge count 0.
- Bit k of the frame (start bit = 0) occupies cycles c0+1+k·P through c0+k·P+P.
- N is the frame length: 10 bits, or 11 with parity.
- Frame-end pulse: `Data_Valid`/`Par_Err`/`Stp_Err` assert at cycle c0+1+(N-1)·P+P/2+2, for exactly one cycle.
  - Example: P=8, no parity gives c0+79.
- A start glitch returns to IDLE at c0+P/2+3.
- Outputs are registered. There is no combinational path from `RX_IN` to any output.
- The frame rate sustained with no gaps is the full line rate: back-to-back frames lose nothing.

## Test plan
- Reset then idle line: hold `RX_IN`=1 for 1000 cycles → all outputs stay 0 and `P_DATA`=0x00.
- P=8, parity off, byte 0xA5 → `Data_Valid` pulses once at c0+79 with `P_DATA`=0xA5; no error pulses.
- P=16, even parity, 0x3C with parity bit 0 → valid pulse with 0x3C. Repeat with parity bit 1 → `Par_Err` pulse, no `Data_Valid`, and `P_DATA` keeps its previous value.
- P=32, odd parity, 0x01, stop bit driven 0 → `Stp_Err` pulse only, and the receiver accepts the next good frame.
- Glitch: `RX_IN` low for 2 cycles at P=16 → return to IDLE at c0+11 with no outputs. Then two back-to-back frames 0x55 and 0xAA → two valid pulses exactly 10·P cycles apart.
- Sampling and reset robustness:
  - A single-cycle inverted spike at edge count P/2 on every bit still decodes 0x96 correctly, because of the majority vote.
  - Assert `rst_n`=0 during data bit 4 → outputs go to 0 the next edge, and a fresh frame afterwards decodes correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a fixed frame format.
// The frame is 1 start bit, 8 data bits (LSB first), an optional parity bit and 1 stop bit.
// Each bit is sampled three times around its centre and decided by a 2-of-3 majority vote.
// Prescale, Par_En and Par_Typ are captured at the start edge and held for the whole frame.
// Handshake: Data_Valid is a one-cycle pulse that qualifies P_DATA. There is no ready or
// back-pressure; the consumer must take P_DATA on the pulse or read the held value later.
// Par_Err and Stp_Err are one-cycle pulses that replace Data_Valid for a bad frame.
module uart_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       Par_En,
    input  logic       Par_Typ,
    output logic [7:0] P_DATA,
    output logic       Data_Valid,
    output logic       Par_Err,
    output logic       Stp_Err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    state_t     next_state;

    // Frame configuration, latched when a start edge is seen in IDLE
    logic [5:0] presc_q;
    logic       par_en_q;
    logic       par_typ_q;

    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [1:0] samp_q;      // [0]: sample at P/2-1, [1]: sample at P/2
    logic [7:0] shift_q;
    logic       par_bad_q;

    logic [5:0] half;
    logic       at_s0;
    logic       at_s1;
    logic       at_s2;
    logic       at_last;
    logic       maj;
    logic       start_edge;

    // Sample points and majority vote. The third sample is the live line value, so the
    // decision is registered at the edge that closes count P/2+1.
    always_comb begin
        half       = {1'b0, presc_q[5:1]};
        at_s0      = (edge_cnt == (half - 6'd1));
        at_s1      = (edge_cnt == half);
        at_s2      = (edge_cnt == (half + 6'd1));
        at_last    = (edge_cnt == (presc_q - 6'd1));
        maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & RX_IN) | (samp_q[1] & RX_IN);
        start_edge = (state == IDLE) && !RX_IN;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A glitching start bit and the stop-bit decision both return to IDLE
    // at the sample point, so the tail of the stop bit is spent waiting for the next start edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!RX_IN) next_state = START;
            end
            START: begin
                if (at_s2 && maj)  next_state = IDLE;
                else if (at_last)  next_state = DATA;
            end
            DATA: begin
                if (at_last && (bit_cnt == 4'd7)) next_state = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (at_last) next_state = STOP;
            end
            STOP: begin
                if (at_s2) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Config latch, edge and bit counters, samples, shift register and parity check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q   <= 6'd0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            edge_cnt  <= 6'd0;
            bit_cnt   <= 4'd0;
            samp_q    <= 2'b00;
            shift_q   <= 8'h00;
            par_bad_q <= 1'b0;
        end else begin
            if (start_edge) begin
                presc_q   <= Prescale;
                par_en_q  <= Par_En;
                par_typ_q <= Par_Typ;
                par_bad_q <= 1'b0;
            end

            if (state == IDLE || next_state == IDLE || at_last) begin
                edge_cnt <= 6'd0;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end

            if (state == DATA) begin
                if (at_last) bit_cnt <= bit_cnt + 4'd1;
            end else begin
                bit_cnt <= 4'd0;
            end

            if (state != IDLE) begin
                if (at_s0) samp_q[0] <= RX_IN;
                if (at_s1) samp_q[1] <= RX_IN;
            end

            if (state == DATA && at_s2) begin
                shift_q <= {maj, shift_q[7:1]};
            end

            // Expected parity bit is the XOR of the data, inverted for odd parity
            if (state == PARITY && at_s2) begin
                par_bad_q <= maj ^ (^shift_q) ^ par_typ_q;
            end
        end
    end

    // Frame-end outputs: exactly one of valid or the error pulses, and P_DATA only on a good frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            P_DATA     <= 8'h00;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stp_Err    <= 1'b0;
            if (state == STOP && at_s2) begin
                if (!par_bad_q && maj) begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shift_q;
                end else begin
                    Par_Err <= par_bad_q;
                    Stp_Err <= !maj;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx with hand-computed frame results.
module tb_uart_rx;

    logic       clk;
    logic       rst_n;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       Par_En;
    logic       Par_Typ;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stp_Err;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Pulses seen on the outputs: cycle, kind {Data_Valid, Par_Err, Stp_Err}, P_DATA
    int         pulse_cyc_q[$];
    logic [2:0] pulse_kind_q[$];
    logic [7:0] pulse_data_q[$];

    logic [7:0] exp_pdata;

    typedef struct {
        int         p;
        logic [7:0] d;
        logic       pe;
        logic       pt;
        logic       pbit;   // parity bit driven on the line
        logic       sbit;   // stop bit driven on the line
        logic       spike;  // invert one cycle at edge count P/2 of every bit
        logic       scr;    // scramble config inputs mid-frame
        logic [2:0] kind;   // expected {Data_Valid, Par_Err, Stp_Err}
        int         lat;    // expected pulse cycle relative to c0
    } vec_t;

    vec_t vecs[8];

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .Par_En     (Par_En),
        .Par_Typ    (Par_Typ),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stp_Err    (Stp_Err)
    );

    // Clock and cycle index
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (Data_Valid || Par_Err || Stp_Err) begin
            pulse_cyc_q.push_back(cyc);
            pulse_kind_q.push_back({Data_Valid, Par_Err, Stp_Err});
            pulse_data_q.push_back(P_DATA);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_pulses();
        pulse_cyc_q.delete();
        pulse_kind_q.delete();
        pulse_data_q.delete();
    endtask

    task automatic drive_level(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 RX_IN = v;
        end
    endtask

    // Drives one frame; bit k of the line is held for cycles c0+k*P .. c0+k*P+P-1
    task automatic send_frame(input int p, input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, input logic spike,
                              input logic scr, output int c0);
        logic [10:0] bits;
        int          n;
        logic        v;
        bits     = {sbit, pbit, d, 1'b0};
        n        = pe ? 11 : 10;
        if (!pe) bits[9] = sbit;
        Prescale = p[5:0];
        Par_En   = pe;
        Par_Typ  = pt;
        c0       = 0;
        for (int k = 0; k < n; k++) begin
            for (int e = 0; e < p; e++) begin
                @(posedge clk);
                #1;
                v = bits[k];
                if (spike && e == p / 2 + 1) v = ~v;
                RX_IN = v;
                if (k == 0 && e == 0) c0 = cyc;
                if (scr && k == 0 && e == 1) begin
                    Prescale = 6'd8;
                    Par_En   = ~pe;
                    Par_Typ  = ~pt;
                end
            end
        end
        Prescale = p[5:0];
        Par_En   = pe;
        Par_Typ  = pt;
    endtask

    initial begin
        int c0;
        int c0b;
        int g0;

        rst_n    = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        Par_En   = 1'b0;
        Par_Typ  = 1'b0;
        exp_pdata = 8'h00;

        //           p   d      pe pt pbit sbit spk scr kind    lat
        vecs[0] = '{8,  8'hA5, 0, 0, 0,   1,   0,  0, 3'b100, 79};
        vecs[1] = '{16, 8'h3C, 1, 0, 0,   1,   0,  0, 3'b100, 171};
        vecs[2] = '{16, 8'h3C, 1, 0, 1,   1,   0,  0, 3'b010, 171};
        vecs[3] = '{32, 8'h01, 1, 1, 0,   0,   0,  0, 3'b001, 339};
        vecs[4] = '{32, 8'h01, 1, 1, 0,   1,   0,  1, 3'b100, 339};
        vecs[5] = '{8,  8'hFF, 1, 0, 0,   1,   0,  0, 3'b100, 87};
        vecs[6] = '{8,  8'h96, 0, 0, 0,   1,   1,  0, 3'b100, 79};
        vecs[7] = '{16, 8'h96, 1, 1, 0,   0,   0,  0, 3'b011, 171};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pdata", P_DATA, 8'h00);
        chk("rst_valid", Data_Valid, 1'b0);
        chk("rst_par_err", Par_Err, 1'b0);
        chk("rst_stp_err", Stp_Err, 1'b0);
        rst_n = 1'b1;

        // Idle line
        clear_pulses();
        drive_level(1'b1, 1000);
        chk("idle_pulses", pulse_cyc_q.size(), 0);
        chk("idle_pdata", P_DATA, 8'h00);

        // Table of single frames
        foreach (vecs[i]) begin
            clear_pulses();
            drive_level(1'b1, 4);
            send_frame(vecs[i].p, vecs[i].d, vecs[i].pe, vecs[i].pt, vecs[i].pbit,
                       vecs[i].sbit, vecs[i].spike, vecs[i].scr, c0);
            drive_level(1'b1, 2 * vecs[i].p);
            chk($sformatf("v%0d_npulse", i), pulse_cyc_q.size(), 1);
            if (pulse_cyc_q.size() > 0) begin
                chk($sformatf("v%0d_cycle", i), pulse_cyc_q[0] - c0, vecs[i].lat);
                chk($sformatf("v%0d_kind", i), pulse_kind_q[0], vecs[i].kind);
                if (vecs[i].kind == 3'b100) exp_pdata = vecs[i].d;
                chk($sformatf("v%0d_pdata", i), pulse_data_q[0], exp_pdata);
            end
            chk($sformatf("v%0d_pdata_hold", i), P_DATA, exp_pdata);
        end

        // Start glitch of 2 cycles at P=16, then a start edge right when IDLE is re-entered,
        // followed by back-to-back frames 0x55 and 0xAA
        clear_pulses();
        Prescale = 6'd16;
        Par_En   = 1'b0;
        drive_level(1'b1, 5);
        @(posedge clk);
        #1 RX_IN = 1'b0;
        g0 = cyc;
        drive_level(1'b0, 1);
        drive_level(1'b1, 9);
        send_frame(16, 8'h55, 0, 0, 0, 1, 0, 0, c0);
        send_frame(16, 8'hAA, 0, 0, 0, 1, 0, 0, c0b);
        drive_level(1'b1, 40);
        chk("b2b_npulse", pulse_cyc_q.size(), 2);
        if (pulse_cyc_q.size() == 2) begin
            chk("glitch_restart_cycle", pulse_cyc_q[0] - g0, 11 + 155);
            chk("b2b_spacing", pulse_cyc_q[1] - pulse_cyc_q[0], 160);
            chk("b2b_kind0", pulse_kind_q[0], 3'b100);
            chk("b2b_kind1", pulse_kind_q[1], 3'b100);
            chk("b2b_data0", pulse_data_q[0], 8'h55);
            chk("b2b_data1", pulse_data_q[1], 8'hAA);
        end
        exp_pdata = 8'hAA;

        // Reset during data bit 4 of 0x3C at P=8
        clear_pulses();
        Prescale = 6'd8;
        drive_level(1'b0, 8);
        drive_level(1'b0, 8);
        drive_level(1'b0, 8);
        drive_level(1'b1, 8);
        drive_level(1'b1, 8);
        drive_level(1'b1, 4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("midrst_pdata", P_DATA, 8'h00);
        chk("midrst_valid", Data_Valid, 1'b0);
        chk("midrst_errs", {Par_Err, Stp_Err}, 2'b00);
        exp_pdata = 8'h00;
        drive_level(1'b1, 200);
        chk("midrst_no_pulse", pulse_cyc_q.size(), 0);
        send_frame(8, 8'h5A, 0, 0, 0, 1, 0, 0, c0);
        drive_level(1'b1, 16);
        chk("post_rst_npulse", pulse_cyc_q.size(), 1);
        if (pulse_cyc_q.size() > 0) begin
            chk("post_rst_cycle", pulse_cyc_q[0] - c0, 79);
            chk("post_rst_kind", pulse_kind_q[0], 3'b100);
            chk("post_rst_data", pulse_data_q[0], 8'h5A);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
